if_id_reg: RTL and testbench
============================

IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Port en, input, 1 bit: load enable (1 = advance, 0 = stall/hold).
REQ-005 Port clc, input, 1 bit: flush request (branch/jump redirect).
REQ-006 Port PCF, input, 32 bits: fetch-stage PC from the PC register.
REQ-007 Port InstrF, input, 32 bits: instruction word fetched at PCF, valid in the same cycle.
REQ-008 Port PCD, output, 32 bits: registered decode-stage PC.
REQ-009 Port PCPlus4D, output, 32 bits: registered PCD+4.
REQ-010 Port InstrD, output, 32 bits: registered decode-stage instruction.
REQ-011 Port ValidD, output, 1 bit: InstrD is a real instruction (1), not a bubble (0).
REQ-012 Port MisalignD, output, 1 bit: the captured PC was not word-aligned.
REQ-013 Port StallCnt, output, 16 bits: count of cycles a valid instruction was held.
REQ-014 Port FlushCnt, output, 16 bits: count of flush events.
REQ-015 Parameter NOP, default 32'h00000013, meaning: bubble encoding (addi x0,x0,0).

Function
REQ-016 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-017 Update priority SHALL be rst > clc > en.
REQ-018 When clc=1 (rst=0), the next state SHALL be a bubble regardless of en: PCD=0, PCPlus4D=0, InstrD=NOP, ValidD=0, MisalignD=0.
REQ-019 When clc=1 (rst=0), FlushCnt SHALL increment by 1, saturating at 16'hFFFF.
REQ-020 When en=1 and clc=0 with PCF[1:0]=2'b00, the block SHALL capture the fetch: PCD<=PCF, PCPlus4D<=PCF+4, InstrD<=InstrF, ValidD<=1, MisalignD<=0.
REQ-021 When en=1 and clc=0 with PCF[1:0]!=2'b00, the block SHALL capture: PCD<=PCF, PCPlus4D<=PCF+4, InstrD<=NOP, ValidD<=0, MisalignD<=1.
REQ-022 When en=0 and clc=0, the block SHALL hold PCD, PCPlus4D, InstrD, ValidD and MisalignD unchanged.
REQ-023 When en=0 and clc=0, StallCnt SHALL increment (saturating at 16'hFFFF) only if ValidD=1 in that cycle.
REQ-024 PCPlus4D SHALL be computed modulo 2^32; PCF=32'hFFFFFFFC SHALL yield PCPlus4D=32'h00000000.
REQ-025 Capture latency SHALL be exactly one cycle: inputs sampled at edge N appear on the outputs after edge N.
REQ-026 Neither counter SHALL wrap; once at 16'hFFFF it SHALL remain there until reset.
REQ-027 Counters SHALL NOT change in cycles where en=1 and clc=0.

Reset
REQ-028 When rst=1 at a rising edge, the block SHALL set PCD=0, PCPlus4D=0, InstrD=NOP, ValidD=0, MisalignD=0, StallCnt=0 and FlushCnt=0, regardless of en and clc.
REQ-029 Reset asserted mid-stall or mid-flush SHALL take effect on that edge with no residual state.
REQ-030 Reset SHALL NOT increment either counter.
REQ-031 The first capture after reset deassertion SHALL follow REQ-020 to REQ-022 unchanged.

Verification
REQ-032 Reset then load: rst=1 for 2 cycles, then en=1, PCF=0x100, InstrF=0x00500093 -> next cycle PCD=0x100, PCPlus4D=0x104, InstrD=0x00500093, ValidD=1.
REQ-033 Stall: after REQ-032, en=0 for 3 cycles with changing PCF/InstrF -> outputs unchanged, StallCnt=3.
REQ-034 Flush during stall: en=0, clc=1 -> InstrD=0x00000013, ValidD=0, PCD=0, FlushCnt=1; a following en=0 cycle leaves StallCnt unchanged.
REQ-035 Misaligned and wrap cases: en=1, PCF=0x102 -> MisalignD=1, ValidD=0, InstrD=NOP; en=1, PCF=0xFFFFFFFC -> PCPlus4D=0.
REQ-036 Saturation: force 65537 stall cycles with ValidD=1 -> StallCnt=0xFFFF and it stays there; rst=1 -> StallCnt=0.
REQ-037 Reset priority: rst=1, clc=1, en=1 together -> reset values per REQ-028, FlushCnt=0.

Source files
------------

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetch PC/instruction, inserts bubbles on flush,
// holds on stall, and keeps saturating stall/flush event counters.
module if_id_reg #(
  parameter logic [31:0] NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clc,
  input  logic [31:0] PCF,
  input  logic [31:0] InstrF,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic [31:0] InstrD,
  output logic        ValidD,
  output logic        MisalignD,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
);

  logic misalign_f;
  assign misalign_f = (PCF[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      PCD       <= '0;
      PCPlus4D  <= '0;
      InstrD    <= NOP;
      ValidD    <= 1'b0;
      MisalignD <= 1'b0;
      StallCnt  <= '0;
      FlushCnt  <= '0;
    end else if (clc) begin
      PCD       <= '0;
      PCPlus4D  <= '0;
      InstrD    <= NOP;
      ValidD    <= 1'b0;
      MisalignD <= 1'b0;
      if (FlushCnt != '1)
        FlushCnt <= FlushCnt + 16'd1;
    end else if (en) begin
      // A misaligned fetch still advances the PC but carries a bubble instead of the word
      PCD       <= PCF;
      PCPlus4D  <= PCF + 32'd4;
      InstrD    <= misalign_f ? NOP : InstrF;
      ValidD    <= ~misalign_f;
      MisalignD <= misalign_f;
    end else if (ValidD && (StallCnt != '1)) begin
      StallCnt <= StallCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the pipeline register.
module tb_if_id_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        clc = 1'b0;
  logic [31:0] PCF = '0;
  logic [31:0] InstrF = '0;
  logic [31:0] PCD, PCPlus4D, InstrD;
  logic        ValidD, MisalignD;
  logic [15:0] StallCnt, FlushCnt;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  longint m_pcd, m_pc4, m_instr;
  int     m_valid, m_mis, m_stall, m_flush;

  if_id_reg #(.NOP(NOP)) dut (
    .clk(clk), .rst(rst), .en(en), .clc(clc), .PCF(PCF), .InstrF(InstrF),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .InstrD(InstrD), .ValidD(ValidD),
    .MisalignD(MisalignD), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  task automatic model_bubble();
    m_pcd = 0; m_pc4 = 0; m_instr = NOP; m_valid = 0; m_mis = 0;
  endtask

  // Advance one clock, update the model from the inputs seen at that edge, sample #1 later
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_bubble();
      m_stall = 0; m_flush = 0;
    end else if (clc) begin
      model_bubble();
      m_flush = (m_flush + 1 > 65535) ? 65535 : m_flush + 1;
    end else if (en) begin
      m_pcd   = longint'(PCF);
      m_pc4   = (longint'(PCF) + 4) % 64'h1_0000_0000;
      m_mis   = (m_pcd % 4 != 0) ? 1 : 0;
      m_valid = 1 - m_mis;
      m_instr = m_mis ? NOP : longint'(InstrF);
    end else if (m_valid == 1) begin
      m_stall = (m_stall + 1 > 65535) ? 65535 : m_stall + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clc = 1'b0;
    tick(); tick();
    checks++;
    if (PCD !== 32'h0 || PCPlus4D !== 32'h0 || InstrD !== NOP || ValidD !== 1'b0 ||
        MisalignD !== 1'b0 || StallCnt !== 16'h0 || FlushCnt !== 16'h0) begin
      failures++;
      $display("FAIL reset: PCD=%h PC4=%h Instr=%h V=%b M=%b SC=%h FC=%h, required 0/0/%h/0/0/0/0",
               PCD, PCPlus4D, InstrD, ValidD, MisalignD, StallCnt, FlushCnt, NOP);
    end
    rst = 1'b0;
  endtask

  task automatic test_load();
    en = 1'b1; PCF = 32'h100; InstrF = 32'h0050_0093;
    tick();
    checks++;
    if (PCD !== 32'h100 || PCPlus4D !== 32'h104 || InstrD !== 32'h0050_0093 ||
        ValidD !== 1'b1 || MisalignD !== 1'b0) begin
      failures++;
      $display("FAIL load: PCD=%h PC4=%h Instr=%h V=%b M=%b, required 100/104/00500093/1/0",
               PCD, PCPlus4D, InstrD, ValidD, MisalignD);
    end
  endtask

  task automatic test_stall();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      PCF = 32'h200 + 32'(i * 4); InstrF = $urandom;
      tick();
      checks++;
      if (PCD !== 32'h100 || PCPlus4D !== 32'h104 || InstrD !== 32'h0050_0093 || ValidD !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold[%0d]: PCD=%h PC4=%h Instr=%h V=%b, required 100/104/00500093/1",
                 i, PCD, PCPlus4D, InstrD, ValidD);
      end
    end
    checks++;
    if (StallCnt !== 16'd3) begin
      failures++;
      $display("FAIL stall_count: got %0d required 3", StallCnt);
    end
  endtask

  task automatic test_flush();
    en = 1'b0; clc = 1'b1;
    tick();
    checks++;
    if (InstrD !== NOP || ValidD !== 1'b0 || PCD !== 32'h0 || PCPlus4D !== 32'h0 || FlushCnt !== 16'd1) begin
      failures++;
      $display("FAIL flush: Instr=%h V=%b PCD=%h PC4=%h FC=%0d, required %h/0/0/0/1",
               InstrD, ValidD, PCD, PCPlus4D, FlushCnt, NOP);
    end
    clc = 1'b0;
    tick();
    checks++;
    if (StallCnt !== 16'd3 || FlushCnt !== 16'd1) begin
      failures++;
      $display("FAIL bubble_stall: SC=%0d FC=%0d, required 3/1", StallCnt, FlushCnt);
    end
  endtask

  task automatic test_misalign_wrap();
    en = 1'b1; PCF = 32'h102; InstrF = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (MisalignD !== 1'b1 || ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'h102 || PCPlus4D !== 32'h106) begin
      failures++;
      $display("FAIL misalign: M=%b V=%b Instr=%h PCD=%h PC4=%h, required 1/0/%h/102/106",
               MisalignD, ValidD, InstrD, PCD, PCPlus4D, NOP);
    end
    PCF = 32'hFFFF_FFFC; InstrF = 32'h0000_0033;
    tick();
    checks++;
    if (PCPlus4D !== 32'h0 || PCD !== 32'hFFFF_FFFC || ValidD !== 1'b1 || MisalignD !== 1'b0 ||
        InstrD !== 32'h33) begin
      failures++;
      $display("FAIL wrap: PC4=%h PCD=%h V=%b M=%b Instr=%h, required 0/fffffffc/1/0/33",
               PCPlus4D, PCD, ValidD, MisalignD, InstrD);
    end
    checks++;
    if (StallCnt !== 16'd3 || FlushCnt !== 16'd1) begin
      failures++;
      $display("FAIL counters_on_load: SC=%0d FC=%0d, required 3/1", StallCnt, FlushCnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 39) == 0);
      clc    = ($urandom_range(0, 7) == 0);
      en     = ($urandom_range(0, 2) != 0);
      PCF    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      InstrF = $urandom;
      tick();
      checks++;
      if (longint'(PCD) != m_pcd || longint'(PCPlus4D) != m_pc4 || longint'(InstrD) != m_instr ||
          int'(ValidD) != m_valid || int'(MisalignD) != m_mis ||
          int'(StallCnt) != m_stall || int'(FlushCnt) != m_flush) begin
        failures++;
        $display("FAIL random[%0d]: PCD=%h PC4=%h I=%h V=%b M=%b SC=%0d FC=%0d, required %h/%h/%h/%0d/%0d/%0d/%0d",
                 i, PCD, PCPlus4D, InstrD, ValidD, MisalignD, StallCnt, FlushCnt,
                 m_pcd, m_pc4, m_instr, m_valid, m_mis, m_stall, m_flush);
      end
    end
    rst = 1'b0; clc = 1'b0; en = 1'b0;
  endtask

  task automatic test_saturation();
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; PCF = 32'h40; InstrF = 32'h0000_0093; tick();
    en = 1'b0;
    for (int i = 0; i < 65537; i++) tick();
    checks++;
    if (StallCnt !== 16'hFFFF || int'(StallCnt) != m_stall) begin
      failures++;
      $display("FAIL stall_saturate: got %h required ffff", StallCnt);
    end
    tick(); tick();
    checks++;
    if (StallCnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL stall_stays_saturated: got %h required ffff", StallCnt);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (StallCnt !== 16'h0) begin
      failures++;
      $display("FAIL stall_reset: got %h required 0", StallCnt);
    end
  endtask

  task automatic test_reset_priority();
    en = 1'b1; clc = 1'b1; tick();
    en = 1'b1; clc = 1'b0; PCF = 32'h80; InstrF = 32'h1234_5678; tick();
    rst = 1'b1; clc = 1'b1; en = 1'b1; PCF = 32'h84;
    tick();
    checks++;
    if (PCD !== 32'h0 || PCPlus4D !== 32'h0 || InstrD !== NOP || ValidD !== 1'b0 ||
        MisalignD !== 1'b0 || StallCnt !== 16'h0 || FlushCnt !== 16'h0) begin
      failures++;
      $display("FAIL reset_priority: PCD=%h PC4=%h I=%h V=%b M=%b SC=%h FC=%h, required 0/0/%h/0/0/0/0",
               PCD, PCPlus4D, InstrD, ValidD, MisalignD, StallCnt, FlushCnt, NOP);
    end
    rst = 1'b0; clc = 1'b0; en = 1'b1; PCF = 32'h88; InstrF = 32'hCAFE_0013;
    tick();
    checks++;
    if (PCD !== 32'h88 || PCPlus4D !== 32'h8C || InstrD !== 32'hCAFE_0013 || ValidD !== 1'b1 ||
        FlushCnt !== 16'h0) begin
      failures++;
      $display("FAIL first_capture: PCD=%h PC4=%h I=%h V=%b FC=%0d, required 88/8c/cafe0013/1/0",
               PCD, PCPlus4D, InstrD, ValidD, FlushCnt);
    end
  endtask

  initial begin
    m_stall = 0; m_flush = 0;
    model_bubble();
    test_reset();
    test_load();
    test_stall();
    test_flush();
    test_misalign_wrap();
    test_random();
    test_saturation();
    test_reset_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
